// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, control
// inputs (halt, redirect) and the downstream instruction handshake.
interface fetch_unit_if #(
  parameter int PC_BITS   = 8,
  parameter int INST_BITS = 16
);
  logic                 o_mem_req;
  logic [PC_BITS-1:0]   o_mem_addr;
  logic [INST_BITS-1:0] i_mem_rdata;
  logic                 i_halt;
  logic                 i_redirect;
  logic [PC_BITS-1:0]   i_redirect_pc;
  logic                 o_inst_valid;
  logic                 i_inst_ready;
  logic [INST_BITS-1:0] o_inst;
  logic [PC_BITS-1:0]   o_inst_pc;
  logic [PC_BITS-1:0]   o_fetch_pc;

  // Fetch unit side.
  modport master (
    output o_mem_req, o_mem_addr, o_inst_valid, o_inst, o_inst_pc, o_fetch_pc,
    input  i_mem_rdata, i_halt, i_redirect, i_redirect_pc, i_inst_ready
  );

  // Memory / control / downstream side.
  modport slave (
    input  o_mem_req, o_mem_addr, o_inst_valid, o_inst, o_inst_pc, o_fetch_pc,
    output i_mem_rdata, i_halt, i_redirect, i_redirect_pc, i_inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-based requests to a 1-cycle-latency memory,
// 2-entry {pc, inst} FIFO towards decode, halt and redirect handling.
module fetch_unit #(
  parameter int                 PC_BITS   = 8,
  parameter int                 INST_BITS = 16,
  parameter logic [PC_BITS-1:0] RESET_PC  = '0
) (
  input logic        i_clk,
  input logic        i_rst,
  fetch_unit_if.master bus
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_HALTED = 2'd1;
  localparam logic [1:0] S_REDIR  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [PC_BITS-1:0]   fetch_pc_q, fetch_pc_d;
  logic                 inflight_q, inflight_d;
  logic [PC_BITS-1:0]   inflight_pc_q, inflight_pc_d;
  logic [1:0]           count_q, count_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic [PC_BITS-1:0]   fifo_pc_q   [2];
  logic [INST_BITS-1:0] fifo_inst_q [2];

  logic pop;
  logic push;
  logic kill;
  logic credit_ok;
  logic mem_req;

  // A response is only ever in flight for one cycle and no request is made
  // in a redirect cycle, so the stale response always lands in the redirect
  // cycle itself; dropping it there is the whole kill mechanism.
  assign kill      = bus.i_redirect;
  assign pop       = (count_q != 2'd0) && bus.i_inst_ready;
  assign push      = inflight_q && !kill;
  assign credit_ok = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
  assign mem_req   = !i_rst && !bus.i_redirect && (state_q == S_RUN) && credit_ok;

  // Next-state logic for PC, in-flight tracking, FIFO pointers and FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = mem_req;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (mem_req) begin
      fetch_pc_d    = fetch_pc_q + PC_BITS'(1);
      inflight_pc_d = fetch_pc_q;
    end

    if (bus.i_redirect) begin
      // Any pop this cycle has already been taken by downstream; then flush.
      fetch_pc_d = bus.i_redirect_pc;
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    if (bus.i_redirect) begin
      state_d = S_REDIR;
    end else begin
      case (state_q)
        S_RUN:    if (bus.i_halt)  state_d = S_HALTED;
        S_HALTED: if (!bus.i_halt) state_d = S_RUN;
        S_REDIR:  state_d = bus.i_halt ? S_HALTED : S_RUN;
        default:  state_d = S_RUN;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (i_rst) begin
      state_q       <= S_RUN;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // FIFO storage write: capture the landing response.
  always_ff @(posedge i_clk) begin
    // NOTE: storage is not reset; count_q gates every read, so stale entries
    // are never visible and the array can map onto plain flops/RAM.
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
      fifo_inst_q[wr_ptr_q] <= bus.i_mem_rdata;
    end
  end

  // The credit rule keeps occupancy + in-flight <= 2, so this never fires.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(push && !pop && (count_q == 2'd2)));

  assign bus.o_mem_req    = mem_req;
  assign bus.o_mem_addr   = fetch_pc_q;
  assign bus.o_fetch_pc   = fetch_pc_q;
  assign bus.o_inst_valid = (count_q != 2'd0);
  assign bus.o_inst       = (count_q != 2'd0) ? fifo_inst_q[rd_ptr_q] : '0;
  assign bus.o_inst_pc    = (count_q != 2'd0) ? fifo_pc_q[rd_ptr_q]   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of expected {pc, inst}
// pushed on each request, popped on each downstream transfer.
`timescale 1ns/1ps
module tb_fetch_unit;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] inst;
  } exp_t;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  exp_t exp_q[$];

  fetch_unit_if #(.PC_BITS(8), .INST_BITS(16)) bus ();

  fetch_unit #(.PC_BITS(8), .INST_BITS(16), .RESET_PC(8'h00)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: returns addr + 0x100 exactly one cycle after the request.
  initial bus.i_mem_rdata = 16'h0000;
  always @(posedge clk)
    if (bus.o_mem_req) bus.i_mem_rdata <= {8'h00, bus.o_mem_addr} + 16'h0100;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare every transfer, flush on redirect/reset, record requests.
  task automatic scoreboard_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else begin
        if (bus.o_inst_valid && bus.i_inst_ready) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_unexpected: got pc=%h inst=%h, want no transfer", bus.o_inst_pc, bus.o_inst);
          end else begin
            e = exp_q.pop_front();
            if (bus.o_inst_pc !== e.pc || bus.o_inst !== e.inst) begin
              tests_failed++;
              $display("FAIL sb_data: got pc=%h inst=%h, want pc=%h inst=%h",
                       bus.o_inst_pc, bus.o_inst, e.pc, e.inst);
            end
          end
        end
        if (bus.i_redirect) exp_q.delete();
        if (bus.o_mem_req) begin
          e.pc   = bus.o_mem_addr;
          e.inst = {8'h00, bus.o_mem_addr} + 16'h0100;
          exp_q.push_back(e);
          tests_run++;
          if (bus.o_fetch_pc !== bus.o_mem_addr) begin
            tests_failed++;
            $display("FAIL fetch_pc_mirror: got fetch_pc=%h, want %h", bus.o_fetch_pc, bus.o_mem_addr);
          end
        end
      end
    end
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1; bus.i_redirect = 1'b0; bus.i_halt = 1'b0; bus.i_inst_ready = rdy;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.i_inst_ready = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    tests_run++;
    if ({bus.o_mem_req, bus.o_inst_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_ctl: got req/valid=%b, want 00", {bus.o_mem_req, bus.o_inst_valid});
    end
    tests_run++;
    if (bus.o_inst !== 16'h0000 || bus.o_inst_pc !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_data: got inst=%h pc=%h, want 0000 00", bus.o_inst, bus.o_inst_pc);
    end
    tests_run++;
    if (bus.o_fetch_pc !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_pc: got %h, want 00", bus.o_fetch_pc);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_stream();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests_run++;
      if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 8'(c)) begin
        tests_failed++;
        $display("FAIL stream_req%0d: got req=%b addr=%h, want 1 %h", c, bus.o_mem_req, bus.o_mem_addr, 8'(c));
      end
      tests_run++;
      if (c < 2) begin
        if (bus.o_inst_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL stream_latency%0d: got valid=%b, want 0", c, bus.o_inst_valid);
        end
      end else if (bus.o_inst_valid !== 1'b1 || bus.o_inst_pc !== 8'(c - 2) ||
                   bus.o_inst !== 16'(16'h0100 + c - 2)) begin
        tests_failed++;
        $display("FAIL stream_out%0d: got v=%b pc=%h inst=%h, want 1 %h %h", c,
                 bus.o_inst_valid, bus.o_inst_pc, bus.o_inst, 8'(c - 2), 16'(16'h0100 + c - 2));
      end
      next_cycle();
    end
    repeat (2) next_cycle();
  endtask

  task automatic test_backpressure();
    int nreq;
    nreq = 0;
    do_reset(1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.o_mem_req === 1'b1) nreq++;
      if (c < 2) begin
        tests_run++;
        if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 8'(c)) begin
          tests_failed++;
          $display("FAIL bp_req%0d: got req=%b addr=%h, want 1 %h", c, bus.o_mem_req, bus.o_mem_addr, 8'(c));
        end
      end else begin
        tests_run++;
        if (bus.o_inst_valid !== 1'b1 || bus.o_inst !== 16'h0100 || bus.o_inst_pc !== 8'h00) begin
          tests_failed++;
          $display("FAIL bp_hold%0d: got v=%b inst=%h pc=%h, want 1 0100 00", c,
                   bus.o_inst_valid, bus.o_inst, bus.o_inst_pc);
        end
      end
      next_cycle();
    end
    tests_run++;
    if (nreq != 2) begin
      tests_failed++;
      $display("FAIL bp_credit: got %0d requests, want 2", nreq);
    end
    bus.i_inst_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (bus.o_inst_valid !== 1'b1 || bus.o_inst_pc !== 8'(c) || bus.o_inst !== 16'(16'h0100 + c)) begin
        tests_failed++;
        $display("FAIL bp_resume%0d: got v=%b pc=%h inst=%h, want 1 %h %h", c,
                 bus.o_inst_valid, bus.o_inst_pc, bus.o_inst, 8'(c), 16'(16'h0100 + c));
      end
      if (c < 2) begin
        tests_run++;
        if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 8'(c + 2)) begin
          tests_failed++;
          $display("FAIL bp_reqresume%0d: got req=%b addr=%h, want 1 %h", c,
                   bus.o_mem_req, bus.o_mem_addr, 8'(c + 2));
        end
      end
      next_cycle();
    end
    repeat (3) next_cycle();
  endtask

  task automatic test_redirect();
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 8'h40;
    @(negedge clk);
    tests_run++;
    if (bus.o_mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL redir_noreq: got req=%b, want 0", bus.o_mem_req);
    end
    next_cycle();
    bus.i_redirect = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.o_inst_valid !== 1'b0 || bus.o_mem_req !== 1'b0 || bus.o_fetch_pc !== 8'h40) begin
      tests_failed++;
      $display("FAIL redir_flush: got v=%b req=%b fpc=%h, want 0 0 40",
               bus.o_inst_valid, bus.o_mem_req, bus.o_fetch_pc);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 8'h40) begin
      tests_failed++;
      $display("FAIL redir_req: got req=%b addr=%h, want 1 40", bus.o_mem_req, bus.o_mem_addr);
    end
    next_cycle();
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (bus.o_inst_valid !== 1'b1 || bus.o_inst_pc !== 8'h40 || bus.o_inst !== 16'h0140) begin
      tests_failed++;
      $display("FAIL redir_first: got v=%b pc=%h inst=%h, want 1 40 0140",
               bus.o_inst_valid, bus.o_inst_pc, bus.o_inst);
    end
    next_cycle();
    // Redirect with a full FIFO and the downstream stalled.
    bus.i_inst_ready = 1'b0;
    repeat (4) next_cycle();
    @(negedge clk);
    tests_run++;
    if (bus.o_inst_valid !== 1'b1 || bus.o_mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_stall: got v=%b req=%b, want 1 0", bus.o_inst_valid, bus.o_mem_req);
    end
    next_cycle();
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 8'h50;
    next_cycle();
    bus.i_redirect = 1'b0; bus.i_inst_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.o_inst_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_flush: got v=%b, want 0", bus.o_inst_valid);
    end
    repeat (6) next_cycle();
  endtask

  task automatic test_wrap();
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 8'hFE;
    next_cycle();
    bus.i_redirect = 1'b0;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 8'(254 + i)) begin
        tests_failed++;
        $display("FAIL wrap_req%0d: got req=%b addr=%h, want 1 %h", i, bus.o_mem_req, bus.o_mem_addr, 8'(254 + i));
      end
      next_cycle();
    end
    repeat (4) next_cycle();
  endtask

  task automatic test_halt();
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 8'h10;
    next_cycle();
    bus.i_redirect = 1'b0;
    repeat (4) next_cycle();
    bus.i_halt = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 8'h13) begin
      tests_failed++;
      $display("FAIL halt_last: got req=%b addr=%h, want 1 13", bus.o_mem_req, bus.o_mem_addr);
    end
    next_cycle();
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.o_mem_req !== 1'b0) begin
        tests_failed++;
        $display("FAIL halt_noreq%0d: got req=%b, want 0", i, bus.o_mem_req);
      end
      if (i == 3) begin
        tests_run++;
        if (bus.o_inst_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL halt_drain: got v=%b, want 0", bus.o_inst_valid);
        end
      end
      next_cycle();
    end
    bus.i_halt = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.o_mem_req !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL halt_exit: got req=%b pending=%0d, want 0 0", bus.o_mem_req, exp_q.size());
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 8'h14) begin
      tests_failed++;
      $display("FAIL halt_restart: got req=%b addr=%h, want 1 14", bus.o_mem_req, bus.o_mem_addr);
    end
    repeat (4) next_cycle();
  endtask

  task automatic test_halt_redirect();
    bus.i_halt = 1'b1;
    next_cycle();
    next_cycle();
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 8'h80;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.o_mem_req !== 1'b0) begin
        tests_failed++;
        $display("FAIL hredir_noreq%0d: got req=%b, want 0", i, bus.o_mem_req);
      end
      if (i == 1) begin
        tests_run++;
        if (bus.o_fetch_pc !== 8'h80) begin
          tests_failed++;
          $display("FAIL hredir_pc: got %h, want 80", bus.o_fetch_pc);
        end
      end
      next_cycle();
      bus.i_redirect = 1'b0;
      if (i == 2) bus.i_halt = 1'b0;
    end
    @(negedge clk);
    tests_run++;
    if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 8'h80) begin
      tests_failed++;
      $display("FAIL hredir_restart: got req=%b addr=%h, want 1 80", bus.o_mem_req, bus.o_mem_addr);
    end
    repeat (4) next_cycle();
  endtask

  task automatic test_reset_mid();
    bus.i_inst_ready = 1'b0;
    repeat (4) next_cycle();
    rst = 1'b1; bus.i_redirect = 1'b1; bus.i_redirect_pc = 8'h33; bus.i_halt = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.o_mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_noreq: got req=%b, want 0", bus.o_mem_req);
    end
    next_cycle();
    rst = 1'b0; bus.i_redirect = 1'b0; bus.i_halt = 1'b0; bus.i_inst_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.o_inst_valid !== 1'b0 || bus.o_inst !== 16'h0000 || bus.o_inst_pc !== 8'h00 ||
        bus.o_fetch_pc !== 8'h00) begin
      tests_failed++;
      $display("FAIL rstmid_state: got v=%b inst=%h pc=%h fpc=%h, want 0 0000 00 00",
               bus.o_inst_valid, bus.o_inst, bus.o_inst_pc, bus.o_fetch_pc);
    end
    tests_run++;
    if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 8'h00) begin
      tests_failed++;
      $display("FAIL rstmid_req: got req=%b addr=%h, want 1 00", bus.o_mem_req, bus.o_mem_addr);
    end
    repeat (5) next_cycle();
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b1;
    bus.i_halt = 1'b0; bus.i_redirect = 1'b0; bus.i_redirect_pc = 8'h00; bus.i_inst_ready = 1'b1;
    fork
      scoreboard_loop();
    join_none
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_halt_redirect();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
